// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls with a multi-cycle hold FSM, dmem-busy freeze, branch flush.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_mem_read,
   input  logic              ex_branch_taken,
   input  logic              dmem_busy,
   output logic              pc_stall,
   output logic              ifid_stall,
   output logic              idex_stall,
   output logic              exmem_stall,
   output logic              idex_bubble,
   output logic              ifid_flush,
   output logic              stall_busy,
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_flush_cnt
);

   // state       | meaning
   // ST_IDLE     | no stall in progress; load-use hazards detected here
   // ST_LOAD_STALL | holding PC/IF-ID and bubbling ID-EX until load data is forwardable
   typedef enum logic {ST_IDLE, ST_LOAD_STALL} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hazard;

   assign hazard = ex_mem_read && (ex_rd != '0) &&
                   ((id_rs1_used && (ex_rd == id_rs1)) || (id_rs2_used && (ex_rd == id_rs2)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      if (dmem_busy) begin
         // EX is frozen, so any branch or hazard seen now is re-evaluated after busy drops
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = ST_IDLE;
         cnt_d       = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hazard) begin
                  pc_stall    = 1'b1;
                  ifid_stall  = 1'b1;
                  idex_bubble = 1'b1;
                  if (LOAD_LAT > 1) begin
                     state_d = ST_LOAD_STALL;
                     cnt_d   = CNT_W'(LOAD_LAT - 1);
                  end
               end
            end
            ST_LOAD_STALL: begin
               pc_stall    = 1'b1;
               ifid_stall  = 1'b1;
               idex_bubble = 1'b1;
               cnt_d       = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign stall_busy = (state_q == ST_LOAD_STALL);

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perf_stall_q, perf_flush_q;
   logic        load_use_evt;

   // a bubble without a flush can only come from a load-use stall
   assign load_use_evt = idex_bubble && !ifid_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (load_use_evt) perf_stall_q <= perf_stall_q + 32'd1;
         if (ifid_flush)   perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: LOAD_LAT=1 and LOAD_LAT=3 instances driven in parallel.
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       u1, u2, mr, br, busy;

   logic a_pc, a_ifs, a_ids, a_exs, a_bub, a_fl, a_sb;
   logic b_pc, b_ifs, b_ids, b_exs, b_bub, b_fl, b_sb;
   logic [31:0] a_pst, a_pfl, b_pst, b_pfl;
   logic [6:0] o1, o3;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(u1), .id_rs2_used(u2), .ex_rd(ex_rd), .ex_mem_read(mr),
      .ex_branch_taken(br), .dmem_busy(busy),
      .pc_stall(a_pc), .ifid_stall(a_ifs), .idex_stall(a_ids), .exmem_stall(a_exs),
      .idex_bubble(a_bub), .ifid_flush(a_fl), .stall_busy(a_sb),
      .perf_stall_cnt(a_pst), .perf_flush_cnt(a_pfl));

   hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(u1), .id_rs2_used(u2), .ex_rd(ex_rd), .ex_mem_read(mr),
      .ex_branch_taken(br), .dmem_busy(busy),
      .pc_stall(b_pc), .ifid_stall(b_ifs), .idex_stall(b_ids), .exmem_stall(b_exs),
      .idex_bubble(b_bub), .ifid_flush(b_fl), .stall_busy(b_sb),
      .perf_stall_cnt(b_pst), .perf_flush_cnt(b_pfl));

   // {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush, stall_busy}
   assign o1 = {a_pc, a_ifs, a_ids, a_exs, a_bub, a_fl, a_sb};
   assign o3 = {b_pc, b_ifs, b_ids, b_exs, b_bub, b_fl, b_sb};

   localparam logic [6:0] Z  = 7'b0000000;
   localparam logic [6:0] H  = 7'b1100100;
   localparam logic [6:0] S  = 7'b1100101;
   localparam logic [6:0] B  = 7'b1111000;
   localparam logic [6:0] BS = 7'b1111001;
   localparam logic [6:0] F  = 7'b0000110;
   localparam logic [6:0] FS = 7'b0000111;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: remaining stall cycles and event tallies per instance
   int          lat [2] = '{1, 3};
   int          rem [2];
   logic [31:0] m_pst [2];
   logic [31:0] m_pfl [2];

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, br, busy;
      logic [6:0] e1, e3;
   } vec_t;
   vec_t tab [23];

   task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pexp(input logic [31:0] m);
`ifdef HAZ_PERF_CNT_EN
      return m;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rem[i] = 0; m_pst[i] = 0; m_pfl[i] = 0;
      end
   endtask

   task automatic model_step(input int i, output logic [6:0] e);
      logic hz;
      hz = mr && (ex_rd != 0) && ((u1 && ex_rd == id_rs1) || (u2 && ex_rd == id_rs2));
      if (busy) begin
         e = (rem[i] > 0) ? BS : B;
      end else if (br) begin
         e = (rem[i] > 0) ? FS : F;
         rem[i] = 0;
         m_pfl[i] = m_pfl[i] + 1;
      end else if (rem[i] > 0) begin
         e = S;
         rem[i] = rem[i] - 1;
         m_pst[i] = m_pst[i] + 1;
      end else if (hz) begin
         e = H;
         rem[i] = lat[i] - 1;
         m_pst[i] = m_pst[i] + 1;
      end else begin
         e = Z;
      end
   endtask

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic v1, input logic v2, input logic ld, input logic b, input logic bz);
      id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
      u1 = v1; u2 = v2; mr = ld; br = b; busy = bz;
   endtask

   // called just after a falling edge with inputs applied; returns at the next falling edge
   task automatic run_cycle(input string tag, input logic use_tab, input logic [6:0] t1, input logic [6:0] t3);
      logic [6:0] e1, e3;
      #1;
      chk32({tag, " perf_stall L1"}, a_pst, pexp(m_pst[0]));
      chk32({tag, " perf_flush L1"}, a_pfl, pexp(m_pfl[0]));
      chk32({tag, " perf_stall L3"}, b_pst, pexp(m_pst[1]));
      chk32({tag, " perf_flush L3"}, b_pfl, pexp(m_pfl[1]));
      model_step(0, e1);
      model_step(1, e3);
      if (use_tab) begin
         chk7({tag, " ctl L1"}, o1, t1);
         chk7({tag, " ctl L3"}, o3, t3);
      end else begin
         chk7({tag, " ctl L1"}, o1, e1);
         chk7({tag, " ctl L3"}, o3, e3);
      end
      @(negedge clk);
   endtask

   task automatic idle_cycle(input string tag);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      run_cycle(tag, 1'b0, Z, Z);
   endtask

   initial begin
      tab[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};
      tab[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, H, H};
      tab[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, S};
      tab[3]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, S};
      tab[4]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};
      tab[5]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, Z, Z};
      tab[6]  = '{5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, Z, Z};
      tab[7]  = '{5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, H, H};
      tab[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B, BS};
      tab[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, B, BS};
      tab[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, S};
      tab[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, S};
      tab[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};
      tab[13] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, H, H};
      tab[14] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F, FS};
      tab[15] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};
      tab[16] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, F, F};
      tab[17] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, B, B};
      tab[18] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, H, H};
      tab[19] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, H, S};
      tab[20] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, S};
      tab[21] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};
      tab[22] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z, Z};

      model_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk7("reset ctl L1", o1, Z);
      chk7("reset ctl L3", o3, Z);
      chk32("reset perf_stall L3", b_pst, 32'd0);
      chk32("reset perf_flush L3", b_pfl, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 23; k++) begin
         drive(tab[k].rs1, tab[k].rs2, tab[k].rd, tab[k].u1, tab[k].u2, tab[k].mr, tab[k].br, tab[k].busy);
         run_cycle($sformatf("vec%0d", k), 1'b1, tab[k].e1, tab[k].e3);
      end

      // reset asserted while the LOAD_LAT=3 instance is mid-stall
      drive(5, 0, 5, 1, 0, 1, 0, 0);
      run_cycle("pre-reset hazard", 1'b1, H, H);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk7("in LOAD_STALL before reset", o3, S);
      #1;
      rst_n = 1'b0;
      #1;
      chk7("mid-stall reset ctl L3", o3, Z);
      chk7("mid-stall reset ctl L1", o1, Z);
      chk32("mid-stall reset perf_stall L3", b_pst, 32'd0);
      chk32("mid-stall reset perf_flush L3", b_pfl, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 3; k++) begin
         drive(5, 0, 5, 1, 0, 1, 0, 0);
         run_cycle($sformatf("perf hazard%0d", k), 1'b0, Z, Z);
         for (int j = 0; j < 3; j++) idle_cycle("perf gap");
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 0);
         run_cycle($sformatf("perf flush%0d", k), 1'b0, Z, Z);
         idle_cycle("perf gap");
      end
      #1;
      chk32("perf_stall L1 after 3 hazards", a_pst, pexp(32'd3));
      chk32("perf_flush L1 after 2 flushes", a_pfl, pexp(32'd2));
      chk32("perf_stall L3 after 3 hazards", b_pst, pexp(32'd9));
      chk32("perf_flush L3 after 2 flushes", b_pfl, pexp(32'd2));
      @(negedge clk);

      for (int k = 0; k < 400; k++) begin
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
         run_cycle($sformatf("rand%0d", k), 1'b0, Z, Z);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
